// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the parametrised UART receiver.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam int   PRESC_MIN = 6;

  // Parity bit the transmitter should have sent for the given data XOR.
  function automatic logic par_expect(input logic data_xor, input logic par_typ);
    return data_xor ^ (par_typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-FF synchroniser, per-bit edge counter and 3-sample
// majority vote around the bit centre.
module uart_rx_sampler #(
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_in,
  input  logic               cnt_clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               rx_sync,
  output logic               vote,
  output logic               vote_stb,
  output logic               bit_end
);

  logic               sync1_reg, sync2_reg;
  logic [PRESC_W-1:0] edge_cnt_reg;
  logic               s0_reg, s1_reg;
  logic [PRESC_W-1:0] half;

  assign half     = presc >> 1;
  assign rx_sync  = sync2_reg;
  assign bit_end  = (edge_cnt_reg == presc - PRESC_W'(1));
  assign vote_stb = (edge_cnt_reg == half + PRESC_W'(1));
  // Third sample is the live synchronised value at the strobe point.
  assign vote     = (s0_reg & s1_reg) | (s0_reg & sync2_reg) | (s1_reg & sync2_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg    <= 1'b1;
      sync2_reg    <= 1'b1;
      edge_cnt_reg <= '0;
      s0_reg       <= 1'b0;
      s1_reg       <= 1'b0;
    end else begin
      sync1_reg <= rx_in;
      sync2_reg <= sync1_reg;
      if (cnt_clr || bit_end) edge_cnt_reg <= '0;
      else                    edge_cnt_reg <= edge_cnt_reg + PRESC_W'(1);
      if (edge_cnt_reg == half - PRESC_W'(1)) s0_reg <= sync2_reg;
      if (edge_cnt_reg == half)               s1_reg <= sync2_reg;
    end
  end

endmodule

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: frame FSM, shift register and valid/ready output.
// Optional break detection is enabled with UART_RX_BREAK_DETECT_EN.
module uart_rx_ext
  import uart_rx_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_in,
  input  logic [PRESC_W-1:0] i_prescale,
  input  logic               i_par_en,
  input  logic               i_par_typ,
  input  logic               i_two_stop,
  input  logic               i_data_ready,
  output logic [DATA_W-1:0]  o_data,
  output logic               o_data_valid,
  output logic               o_par_err,
  output logic               o_frm_err,
  output logic               o_overrun,
  output logic               o_break
);

  localparam int BC_W = $clog2(DATA_W);

  state_t             state_reg, state_next;
  logic [PRESC_W-1:0] presc_reg, presc_norm;
  logic               par_en_reg, par_typ_reg, two_stop_reg;
  logic [DATA_W-1:0]  shift_reg;
  logic [BC_W-1:0]    bit_cnt_reg;
  logic               stop_cnt_reg;
  logic               par_err_reg, frm_err_reg;
  logic               rx_sync, vote, vote_stb, bit_end, cnt_clr;
  logic               start_det, publish;
`ifdef UART_RX_BREAK_DETECT_EN
  logic               zero_reg, brk_det;
`endif

  // Odd prescale rounds down, anything below the minimum is lifted to it.
  assign presc_norm = (i_prescale < PRESC_W'(PRESC_MIN)) ? PRESC_W'(PRESC_MIN)
                                                         : (i_prescale & ~PRESC_W'(1));

  uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
    .clk      (i_clk),
    .rst_n    (i_reset),
    .rx_in    (i_rx_in),
    .cnt_clr  (cnt_clr),
    .presc    (presc_reg),
    .rx_sync  (rx_sync),
    .vote     (vote),
    .vote_stb (vote_stb),
    .bit_end  (bit_end)
  );

  always_comb begin
    state_next = state_reg;
    start_det  = 1'b0;
    publish    = 1'b0;
    cnt_clr    = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
    brk_det    = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_sync) begin
          state_next = START;
          start_det  = 1'b1;
        end
      end
      START: begin
        if (vote_stb && vote) state_next = IDLE;
        else if (bit_end)     state_next = DATA;
      end
      DATA: begin
        if (bit_end && bit_cnt_reg == BC_W'(DATA_W - 1))
          state_next = par_en_reg ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        // Leave at the last stop-bit vote so a back-to-back start is not missed.
        if (vote_stb && (stop_cnt_reg == two_stop_reg)) begin
          cnt_clr    = 1'b1;
          state_next = IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
          if (zero_reg && !vote) begin
            state_next = BREAK;
            brk_det    = 1'b1;
          end else begin
            publish = 1'b1;
          end
`else
          publish = 1'b1;
`endif
        end
      end
      BREAK: begin
`ifdef UART_RX_BREAK_DETECT_EN
        // Edge counter doubles as the run length of consecutive idle samples.
        cnt_clr = !rx_sync;
        if (rx_sync && bit_end) state_next = IDLE;
`else
        cnt_clr    = 1'b1;
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg    <= IDLE;
      presc_reg    <= PRESC_W'(PRESC_MIN);
      par_en_reg   <= 1'b0;
      par_typ_reg  <= PAR_EVEN;
      two_stop_reg <= 1'b0;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      par_err_reg  <= 1'b0;
      frm_err_reg  <= 1'b0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_par_err    <= 1'b0;
      o_frm_err    <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_det) begin
        presc_reg    <= presc_norm;
        par_en_reg   <= i_par_en;
        par_typ_reg  <= i_par_typ;
        two_stop_reg <= i_two_stop;
        bit_cnt_reg  <= '0;
        stop_cnt_reg <= 1'b0;
        par_err_reg  <= 1'b0;
        frm_err_reg  <= 1'b0;
      end
      if (vote_stb) begin
        case (state_reg)
          DATA:    shift_reg   <= {vote, shift_reg[DATA_W-1:1]};
          PARITY:  par_err_reg <= (vote != par_expect(^shift_reg, par_typ_reg));
          STOP:    if (!vote) frm_err_reg <= 1'b1;
          default: ;
        endcase
      end
      if (bit_end) begin
        if (state_reg == DATA) bit_cnt_reg  <= bit_cnt_reg + BC_W'(1);
        if (state_reg == STOP) stop_cnt_reg <= 1'b1;
      end

      o_overrun <= 1'b0;
      if (publish && (!o_data_valid || i_data_ready)) begin
        o_data       <= shift_reg;
        o_par_err    <= par_err_reg;
        o_frm_err    <= frm_err_reg | !vote;
        o_data_valid <= 1'b1;
      end else if (publish) begin
        o_overrun <= 1'b1;
      end else if (i_data_ready) begin
        o_data_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      zero_reg <= 1'b0;
      o_break  <= 1'b0;
    end else begin
      o_break <= brk_det;
      if (start_det)
        zero_reg <= 1'b1;
      else if (vote_stb && (state_reg == DATA || state_reg == PARITY || state_reg == STOP))
        zero_reg <= zero_reg & !vote;
    end
  end
`else
  assign o_break = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ext.sv
// Self-checking bench for uart_rx_ext: directed table, corner sequences and
// randomized frames against a frame-level reference model.
module tb_uart_rx_ext;
  import uart_rx_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [5:0] presc = 6'd8;
  logic       par_en = 1'b0, par_typ = 1'b0, two_stop = 1'b0, ready = 1'b1;

  logic [7:0] d8_data;
  logic       d8_valid, d8_par, d8_frm, d8_ovr, d8_brk;
  logic [6:0] d7_data;
  logic       d7_valid, d7_par, d7_frm, d7_ovr, d7_brk;

  always #5 clk = ~clk;

  uart_rx_ext #(.DATA_W(8), .PRESC_W(6)) dut8 (
    .i_clk(clk), .i_reset(rst_n), .i_rx_in(rx), .i_prescale(presc),
    .i_par_en(par_en), .i_par_typ(par_typ), .i_two_stop(two_stop),
    .i_data_ready(ready), .o_data(d8_data), .o_data_valid(d8_valid),
    .o_par_err(d8_par), .o_frm_err(d8_frm), .o_overrun(d8_ovr), .o_break(d8_brk)
  );

  uart_rx_ext #(.DATA_W(7), .PRESC_W(6)) dut7 (
    .i_clk(clk), .i_reset(rst_n), .i_rx_in(rx), .i_prescale(presc),
    .i_par_en(par_en), .i_par_typ(par_typ), .i_two_stop(two_stop),
    .i_data_ready(ready), .o_data(d7_data), .o_data_valid(d7_valid),
    .o_par_err(d7_par), .o_frm_err(d7_frm), .o_overrun(d7_ovr), .o_break(d7_brk)
  );

  typedef struct {
    logic [8:0] data;
    logic       par;
    logic       frm;
  } word_t;

  typedef struct {
    int         presc;
    int         dw;
    logic [8:0] data;
    bit         pe, pt, pb, ts, s0, s1;
    logic [8:0] xd;
    bit         xp, xf;
  } vec_t;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  word_t       q8[$];
  word_t       q7[$];
  int          ovr8 = 0, brk8 = 0, ovr7 = 0, brk7 = 0;
  bit          seen8 = 0, seen7 = 0;
  int unsigned fv8 = 0, fv7 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Accepted words, pulse counts and first-valid time, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (d8_valid && ready) q8.push_back('{data: {1'b0, d8_data}, par: d8_par, frm: d8_frm});
      if (d7_valid && ready) q7.push_back('{data: {2'b0, d7_data}, par: d7_par, frm: d7_frm});
      if (d8_valid && !seen8) begin seen8 = 1; fv8 = cyc; end
      if (d7_valid && !seen7) begin seen7 = 1; fv7 = cyc; end
      if (d8_ovr) ovr8++;
      if (d8_brk) brk8++;
      if (d7_ovr) ovr7++;
      if (d7_brk) brk7++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    q8.delete(); q7.delete();
    ovr8 = 0; brk8 = 0; ovr7 = 0; brk7 = 0;
    seen8 = 0; seen7 = 0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    rx = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    clear_mon();
  endtask

  function automatic int eff_p(input int pr);
    return (pr < 6) ? 6 : (pr & ~1);
  endfunction

  // Frame-level model: what the receiver should report for a given serial frame.
  function automatic word_t model(input int dw, input logic [8:0] data, input bit pe,
                                  input bit pt, input bit pb, input bit ts,
                                  input bit s0, input bit s1, output bit brk);
    word_t      w;
    logic [8:0] m;
    m      = data & 9'((1 << dw) - 1);
    w.data = m;
    w.par  = pe && (pb != ((^m) ^ pt));
    w.frm  = !s0 || (ts && !s1);
    brk    = (m == 0) && (!pe || !pb) && !s0 && (!ts || !s1);
    return w;
  endfunction

  task automatic send_bit(input logic b, input int p);
    rx = b;
    tick(p);
  endtask

  task automatic send_frame(input int p, input int dw, input logic [8:0] data, input bit pe,
                            input bit pb, input bit ts, input bit s0, input bit s1,
                            input bit scramble);
    logic [5:0] sv_presc;
    logic       sv_pe, sv_pt, sv_ts;
    sv_presc = presc; sv_pe = par_en; sv_pt = par_typ; sv_ts = two_stop;
    start_cyc = cyc;
    send_bit(1'b0, p);
    if (scramble) begin
      presc = 6'($urandom); par_en = 1'($urandom);
      par_typ = 1'($urandom); two_stop = 1'($urandom);
    end
    for (int i = 0; i < dw; i++) send_bit(data[i], p);
    if (pe) send_bit(pb, p);
    send_bit(s0, p);
    if (ts) send_bit(s1, p);
    rx = 1'b1;
    presc = sv_presc; par_en = sv_pe; par_typ = sv_pt; two_stop = sv_ts;
  endtask

  task automatic check_word(input string tag, input int which, input word_t exp,
                            input int exp_lat);
    word_t w;
    int    n;
    n = (which == 8) ? q8.size() : q7.size();
    check({tag, "_count"}, 32'(n), 32'd1);
    if (n > 0) begin
      w = (which == 8) ? q8.pop_front() : q7.pop_front();
      check({tag, "_data"}, 32'(w.data), 32'(exp.data));
      check({tag, "_par"}, 32'(w.par), 32'(exp.par));
      check({tag, "_frm"}, 32'(w.frm), 32'(exp.frm));
    end
    if (exp_lat > 0)
      check({tag, "_lat"}, (which == 8) ? fv8 - start_cyc : fv7 - start_cyc, 32'(exp_lat));
  endtask

  vec_t vecs[8];

  initial begin
    word_t w;
    bit    brk;
    int    p;

    vecs[0] = '{8,  8, 9'h0A5, 0, 0, 0, 0, 1, 1, 9'h0A5, 0, 0};
    vecs[1] = '{16, 8, 9'h003, 1, 0, 1, 0, 1, 1, 9'h003, 1, 0};
    vecs[2] = '{16, 8, 9'h003, 1, 1, 1, 0, 1, 1, 9'h003, 0, 0};
    vecs[3] = '{12, 7, 9'h02B, 0, 0, 0, 1, 1, 0, 9'h02B, 0, 1};
    vecs[4] = '{7,  8, 9'h0FF, 1, 1, 1, 1, 1, 1, 9'h0FF, 0, 0};
    vecs[5] = '{3,  8, 9'h0C3, 1, 0, 0, 0, 0, 1, 9'h0C3, 0, 1};
    vecs[6] = '{63, 7, 9'h055, 1, 0, 1, 0, 1, 1, 9'h055, 1, 0};
    vecs[7] = '{10, 7, 9'h07F, 1, 1, 0, 1, 1, 1, 9'h07F, 0, 0};

    // Reset state
    tick(3);
    check("rst_data", 32'(d8_data), 32'd0);
    check("rst_valid", 32'(d8_valid), 32'd0);
    check("rst_flags", 32'({d8_par, d8_frm, d8_ovr, d8_brk}), 32'd0);
    rst_n = 1'b1;
    tick(3);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      int   s;
      v = vecs[i];
      do_reset();
      presc = 6'(v.presc); par_en = v.pe; par_typ = v.pt; two_stop = v.ts; ready = 1'b1;
      p = eff_p(v.presc);
      send_frame(p, v.dw, v.data, v.pe, v.pb, v.ts, v.s0, v.s1, 1'b0);
      tick(3 * p);
      s = 1 + v.dw + int'(v.pe) + int'(v.ts);
      w = '{data: v.xd, par: v.xp, frm: v.xf};
      check_word($sformatf("vec%0d", i), v.dw, w, 5 + s * p + p / 2);
    end

    // Start glitch shorter than half a bit
    do_reset();
    presc = 6'd16; par_en = 0; two_stop = 0; ready = 1;
    rx = 1'b0; tick(3); rx = 1'b1; tick(40);
    check("glitch_nopub", 32'(q8.size()), 32'd0);
    check("glitch_valid", 32'(d8_valid), 32'd0);
    check("glitch_idle", 32'(dut8.state_reg), 32'(IDLE));
    send_frame(16, 8, 9'h05A, 0, 0, 0, 1, 1, 1'b0);
    tick(48);
    check_word("glitch_next", 8, '{data: 9'h05A, par: 0, frm: 0}, 0);

    // Overrun on back-to-back frames with consumer stalled
    do_reset();
    presc = 6'd8; ready = 1'b0;
    send_frame(8, 8, 9'h011, 0, 0, 0, 1, 1, 1'b0);
    send_frame(8, 8, 9'h022, 0, 0, 0, 1, 1, 1'b0);
    tick(24);
    check("ovr_pulses", 32'(ovr8), 32'd1);
    check("ovr_data", 32'(d8_data), 32'h11);
    check("ovr_valid", 32'(d8_valid), 32'd1);
    ready = 1'b1;
    @(negedge clk);
    check("ovr_valid_hold", 32'(d8_valid), 32'd1);
    tick(1);
    check("ovr_valid_drop", 32'(d8_valid), 32'd0);

    // Line held low for 12 bit times
    do_reset();
    presc = 6'd8; ready = 1'b1;
    rx = 1'b0; tick(96); rx = 1'b1; tick(32);
`ifdef UART_RX_BREAK_DETECT_EN
    check("brk_pulses", 32'(brk8), 32'd1);
    check("brk_nopub", 32'(q8.size()), 32'd0);
`else
    check("brk_tied0", 32'(brk8), 32'd0);
    check("brk_pub", 32'(q8.size() > 0), 32'd1);
    if (q8.size() > 0) begin
      w = q8.pop_front();
      check("brk_data", 32'(w.data), 32'd0);
      check("brk_frm", 32'(w.frm), 32'd1);
    end
`endif

    // Async reset in the middle of DATA, with a held word on the output
    do_reset();
    presc = 6'd8; ready = 1'b0;
    send_frame(8, 8, 9'h0E7, 0, 0, 0, 0, 1, 1'b0);
    tick(16);
    check("arst_pre_valid", 32'(d8_valid), 32'd1);
    check("arst_pre_frm", 32'(d8_frm), 32'd1);
    send_bit(1'b0, 8); send_bit(1'b1, 8); send_bit(1'b0, 8); send_bit(1'b1, 4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_data", 32'(d8_data), 32'd0);
    check("arst_valid", 32'(d8_valid), 32'd0);
    check("arst_flags", 32'({d8_par, d8_frm, d8_ovr, d8_brk}), 32'd0);
    rx = 1'b1; tick(2); rst_n = 1'b1; tick(2);
    clear_mon(); ready = 1'b1;
    tick(60);
    check("arst_quiet", 32'(ovr8 + brk8 + q8.size()), 32'd0);
    send_frame(8, 8, 9'h03C, 0, 0, 0, 1, 1, 1'b0);
    tick(24);
    check_word("arst_next", 8, '{data: 9'h03C, par: 0, frm: 0}, 0);

    // Randomized frames on the 8-bit receiver
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int         pr;
      logic [8:0] d;
      bit         pe, pt, pb, ts, s0, s1;
      pr = $urandom_range(0, 24);
      p  = eff_p(pr);
      d  = 9'($urandom_range(0, 255));
      pe = 1'($urandom); pt = 1'($urandom); ts = 1'($urandom);
      pb = (^d[7:0]) ^ pt ^ ($urandom_range(0, 3) == 0);
      s0 = ($urandom_range(0, 4) != 0);
      s1 = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 7) == 0) begin
        d = '0; pb = 0; s0 = 0; s1 = 0;
      end
      presc = 6'(pr); par_en = pe; par_typ = pt; two_stop = ts;
      clear_mon();
      send_frame(p, 8, d, pe, pb, ts, s0, s1, 1'b1);
      tick(2 * p + 6 + int'($urandom_range(0, 5)));
      w = model(8, d, pe, pt, pb, ts, s0, s1, brk);
`ifdef UART_RX_BREAK_DETECT_EN
      if (brk) begin
        check($sformatf("rnd%0d_brk", i), 32'(brk8), 32'd1);
        check($sformatf("rnd%0d_nopub", i), 32'(q8.size()), 32'd0);
      end else begin
        check_word($sformatf("rnd%0d", i), 8, w, 0);
      end
`else
      check_word($sformatf("rnd%0d", i), 8, w, 0);
`endif
      check($sformatf("rnd%0d_ovr", i), 32'(ovr8), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
